lb_rx_ctrl: RTL and testbench

Serial receive controller for the local-bus UART link. Detects a start edge on the serial line, generates mid-bit sample strobes for the downstream 12-bit receive shift register, and counts 12 bits per frame. When the frame is complete, it reads back the assembled word, checks framing and parity, and presents the byte to the host through a ready/read handshake with overrun detection.

---
 rtl/lb_uart_pkg.sv | 25 ++
 rtl/lb_sync2.sv | 28 ++
 rtl/lb_rx_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lb_rx_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_uart_pkg.sv
// lb_uart_pkg
//   Definitions shared by the local-bus UART receive path.
//   - rx_state_t : receive controller state encoding
//   - FRAME_BITS : bits per serial frame (start + 8 data + parity + 2 stop)
//   - *_POS/LSB  : bit positions inside the assembled 12-bit frame word,
//                  where bit 0 is the first bit received on the line
package lb_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_CHECK = 2'd3
  } rx_state_t;

  localparam int FRAME_BITS = 12;

  localparam int START_POS  = 0;
  localparam int DATA_LSB   = 1;
  localparam int DATA_MSB   = DATA_LSB + 7;
  localparam int PARITY_POS = 9;
  localparam int STOP0_POS  = 10;
  localparam int STOP1_POS  = 11;

endpackage

// File: rtl/lb_sync2.sv
// lb_sync2
//   Two-flop synchronizer for a single asynchronous input. Both flops
//   reset to 1 so an idle-high serial line shows no edge out of reset.
// Ports:
//   clk   in  1  destination clock
//   reset in  1  asynchronous, active-low reset
//   d     in  1  asynchronous input
//   q     out 1  synchronized output (two clocks of latency)
module lb_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lb_rx_ctrl.sv
// lb_rx_ctrl
//   Serial receive controller for the local-bus UART link. Detects the
//   start edge, issues mid-bit shift strobes to an external 12-bit shift
//   register, then evaluates the assembled frame (framing + even parity)
//   and hands the byte to the host with a ready/read handshake.
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4)
// Ports:
//   clk         in  1   system clock, rising edge
//   reset       in  1   asynchronous, active-low reset
//   rx          in  1   serial line (asynchronous, idle high)
//   shift       out 1   one-cycle strobe to the shift register
//   sample      out 1   synchronized bit value, valid while shift = 1
//   frame_in    in  12  assembled frame, bit 0 = first bit received
//   rd          in  1   host read strobe, clears rx_ready
//   rx_data     out 8   received byte
//   rx_valid    out 1   one-cycle pulse per completed frame
//   rx_ready    out 1   byte available and not yet read
//   frame_err   out 1   last frame had a bad start or stop bit
//   parity_err  out 1   last frame failed even parity
//   overrun     out 1   sticky: frame completed while rx_ready was set
module lb_rx_ctrl
  import lb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        shift,
  output logic        sample,
  input  logic [11:0] frame_in,
  input  logic        rd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_ready,
  output logic        frame_err,
  output logic        parity_err,
  output logic        overrun
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  // shift is registered, so the terminal counts sit one cycle before the
  // cycle in which the strobe must be visible. The counter is 0 on the
  // first START cycle, which is already one cycle after the edge cycle.
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 2);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BITS_LAST = 4'(FRAME_BITS);

  logic              rx_s;
  logic              rx_s_d;
  rx_state_t         state;
  rx_state_t         state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_nxt;
  logic [3:0]        bit_cnt;
  logic [3:0]        bit_nxt;
  logic              shift_nxt;
  logic              check;

  lb_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign check = (state == ST_CHECK);

  // State, counters and the shift strobe are all registered together so
  // shift lines up exactly with the bit counter value it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= 1'b0;
      rx_s_d   <= 1'b1;
      sample   <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      rx_s_d   <= rx_s;
      sample   <= rx_s;
    end
  end

  // Next-state logic. Falling edges outside IDLE are ignored because only
  // IDLE looks at rx_s_d/rx_s.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt + BAUD_W'(1);
    bit_nxt   = bit_cnt;
    shift_nxt = 1'b0;

    unique case (state)
      ST_IDLE: begin
        baud_nxt = '0;
        if (rx_s_d && !rx_s) begin
          state_nxt = ST_START;
        end
      end

      ST_START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_nxt = '0;
          // Line back high at mid start bit: treat as a glitch.
          if (rx_s) begin
            state_nxt = ST_IDLE;
          end else begin
            shift_nxt = 1'b1;
            bit_nxt   = 4'd1;
            state_nxt = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        // The 12th strobe is out this cycle; frame_in settles next cycle.
        if (bit_cnt == BITS_LAST) begin
          baud_nxt  = '0;
          state_nxt = ST_CHECK;
        end else if (baud_cnt == BAUD_LAST) begin
          baud_nxt  = '0;
          shift_nxt = 1'b1;
          bit_nxt   = bit_cnt + 4'd1;
        end
      end

      ST_CHECK: begin
        baud_nxt  = '0;
        bit_nxt   = '0;
        state_nxt = ST_IDLE;
      end

      default: begin
        baud_nxt  = '0;
        bit_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Host-facing result registers. A completion in the same cycle as rd
  // keeps rx_ready set (the new byte has not been read) and is not an
  // overrun, since the previous byte is being consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_ready   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_valid <= check;
      if (check) begin
        rx_data    <= frame_in[DATA_MSB:DATA_LSB];
        frame_err  <= frame_in[START_POS] | ~frame_in[STOP0_POS] | ~frame_in[STOP1_POS];
        parity_err <= ^frame_in[PARITY_POS:DATA_LSB];
        rx_ready   <= 1'b1;
        if (rx_ready && !rd) begin
          overrun <= 1'b1;
        end
      end else if (rd) begin
        rx_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lb_rx_ctrl.sv
// tb_lb_rx_ctrl
//   Self-checking bench for lb_rx_ctrl with CLKS_PER_BIT = 16 and a
//   behavioural 12-bit shift register beside the DUT. A frame-level model
//   predicts, from what the bench transmits, on which cycle each shift
//   strobe and each rx_valid pulse must appear and what the result flags
//   must be; a per-cycle compare process checks every output against it.
module tb_lb_rx_ctrl;
  import lb_uart_pkg::*;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // rx reaches rx_s two clocks after the bench drives it.
  localparam int SYNC_LAT = 2;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        shift;
  logic        sample;
  logic [11:0] frame_in;
  logic        rd;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        frame_err;
  logic        parity_err;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int   shift_q[$];
  exp_t frame_q[$];

  logic       m_ready;
  logic       m_overrun;
  logic [7:0] m_data;
  logic       m_ferr;
  logic       m_perr;
  logic       exp_shift;
  logic       exp_valid;
  exp_t       e;

  logic [2:0] rx_hist;
  logic       rd_q;

  int shift_total     = 0;
  int valid_total     = 0;
  int shifts_in_frame = 0;
  int first_shift_cyc = 0;
  int last_spacing    = 0;

  always #5 clk = ~clk;

  lb_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .shift      (shift),
    .sample     (sample),
    .frame_in   (frame_in),
    .rd         (rd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  // External receive shift register: first bit received ends up in bit 0.
  always @(posedge clk or negedge reset) begin
    if (!reset) frame_in <= '0;
    else if (shift) frame_in <= {sample, frame_in[11:1]};
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Line history (sample is the line value seen two edges earlier) and
  // the rd value seen at the most recent edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_hist <= 3'b111;
      rd_q    <= 1'b0;
    end else begin
      rx_hist <= {rx_hist[1:0], rx};
      rd_q    <= rd;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Per-cycle comparison against the frame-level model.
  always @(negedge clk) begin
    if (!reset) begin
      shift_q.delete();
      frame_q.delete();
      m_ready         = 1'b0;
      m_overrun       = 1'b0;
      m_data          = 8'h00;
      m_ferr          = 1'b0;
      m_perr          = 1'b0;
      shifts_in_frame = 0;
    end else begin
      exp_shift = 1'b0;
      if (shift_q.size() > 0 && shift_q[0] == cyc) begin
        exp_shift = 1'b1;
        void'(shift_q.pop_front());
      end
      exp_valid = 1'b0;
      if (frame_q.size() > 0 && frame_q[0].cyc == cyc) begin
        exp_valid = 1'b1;
        e = frame_q.pop_front();
        if (m_ready && !rd_q) m_overrun = 1'b1;
        m_ready = 1'b1;
        m_data  = e.data;
        m_ferr  = e.ferr;
        m_perr  = e.perr;
      end else if (rd_q) begin
        m_ready = 1'b0;
      end

      if (shift) begin
        if (shifts_in_frame == 0) first_shift_cyc = cyc;
        shifts_in_frame++;
        shift_total++;
      end
      if (rx_valid) begin
        valid_total++;
        last_spacing    = cyc - first_shift_cyc;
        shifts_in_frame = 0;
      end

      checkOutput("shift",      shift,      exp_shift);
      checkOutput("sample",     sample,     rx_hist[2]);
      checkOutput("rx_valid",   rx_valid,   exp_valid);
      checkOutput("rx_ready",   rx_ready,   m_ready);
      checkOutput("overrun",    overrun,    m_overrun);
      checkOutput("rx_data",    rx_data,    m_data);
      checkOutput("frame_err",  frame_err,  m_ferr);
      checkOutput("parity_err", parity_err, m_perr);
    end
  end

  function automatic logic [11:0] makeFrame(input logic [7:0] data, input bit bad_parity,
                                            input bit stop0, input bit stop1);
    logic par;
    par = (($countones(data) % 2) == 1) ^ bad_parity;
    return {stop1, stop0, par, data, 1'b0};
  endfunction

  // Transmit the first nbits bits of a frame (called on a negedge) and
  // register the full-frame expectations with the model.
  task automatic applyStimulus(input logic [11:0] bits, input int nbits);
    int         n0;
    logic [7:0] d;
    exp_t       x;
    n0 = cyc;
    for (int k = 1; k <= FRAME_BITS; k++)
      shift_q.push_back(n0 + SYNC_LAT + HALF + (k - 1) * CPB);
    d      = bits[8:1];
    x.cyc  = n0 + SYNC_LAT + HALF + (FRAME_BITS - 1) * CPB + 2;
    x.data = d;
    x.ferr = (bits[0] != 1'b0) || (bits[10] != 1'b1) || (bits[11] != 1'b1);
    x.perr = ((($countones(d) + int'(bits[9])) % 2) != 0);
    frame_q.push_back(x);
    for (int k = 0; k < nbits; k++) begin
      rx = bits[k];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic readPulse();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_shift"},      shift,      1'b0);
    checkOutput({tag, "_sample"},     sample,     1'b1);
    checkOutput({tag, "_rx_data"},    rx_data,    8'h00);
    checkOutput({tag, "_rx_valid"},   rx_valid,   1'b0);
    checkOutput({tag, "_rx_ready"},   rx_ready,   1'b0);
    checkOutput({tag, "_frame_err"},  frame_err,  1'b0);
    checkOutput({tag, "_parity_err"}, parity_err, 1'b0);
    checkOutput({tag, "_overrun"},    overrun,    1'b0);
  endtask

  initial begin
    int v0;
    int s0;
    int kind;
    int gap;
    logic [7:0] data;

    reset = 1'b0;
    rx    = 1'b1;
    rd    = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("por");
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Clean byte, then host read.
    v0 = valid_total;
    applyStimulus(makeFrame(8'hA5, 0, 1, 1), 12);
    repeat (2) @(negedge clk);
    checkOutput("s1_valid_count", valid_total - v0, 1);
    checkOutput("s1_rx_data",     rx_data,    8'hA5);
    checkOutput("s1_frame_err",   frame_err,  1'b0);
    checkOutput("s1_parity_err",  parity_err, 1'b0);
    checkOutput("s1_rx_ready",    rx_ready,   1'b1);
    readPulse();
    checkOutput("s1_ready_after_rd", rx_ready, 1'b0);

    // Wrong parity.
    applyStimulus(makeFrame(8'h01, 1, 1, 1), 12);
    repeat (2) @(negedge clk);
    checkOutput("s2_rx_data",    rx_data,    8'h01);
    checkOutput("s2_parity_err", parity_err, 1'b1);
    checkOutput("s2_frame_err",  frame_err,  1'b0);
    readPulse();

    // Bad second stop bit.
    v0 = valid_total;
    applyStimulus(makeFrame(8'h3C, 0, 1, 0), 12);
    repeat (2) @(negedge clk);
    checkOutput("s3_valid_count", valid_total - v0, 1);
    checkOutput("s3_frame_err",   frame_err, 1'b1);
    checkOutput("s3_rx_data",     rx_data,   8'h3C);
    readPulse();

    // Short low glitch must not start a frame.
    v0 = valid_total;
    s0 = shift_total;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("s4_shift_count", shift_total - s0, 0);
    checkOutput("s4_valid_count", valid_total - v0, 0);

    // Back-to-back frames without a read.
    checkOutput("s5_overrun_before", overrun, 1'b0);
    applyStimulus(makeFrame(8'h11, 0, 1, 1), 12);
    applyStimulus(makeFrame(8'h22, 0, 1, 1), 12);
    repeat (2) @(negedge clk);
    checkOutput("s5_overrun", overrun,      1'b1);
    checkOutput("s5_rx_data", rx_data,      8'h22);
    checkOutput("s5_spacing", last_spacing, 11 * 16 + 2);

    // Reset after the 6th shift aborts the frame.
    s0 = shift_total;
    applyStimulus(makeFrame(8'h77, 0, 1, 1), 6);
    checkOutput("s6_shifts_before_reset", shift_total - s0, 6);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    checkResetValues("s6_reset");
    reset = 1'b1;
    repeat (5) @(negedge clk);
    v0 = valid_total;
    applyStimulus(makeFrame(8'h5A, 0, 1, 1), 12);
    repeat (2) @(negedge clk);
    checkOutput("s6_valid_count", valid_total - v0, 1);
    checkOutput("s6_rx_data",     rx_data,   8'h5A);
    checkOutput("s6_frame_err",   frame_err, 1'b0);
    checkOutput("s6_overrun",     overrun,   1'b0);

    // Randomized frames, errors, gaps and reads.
    for (int i = 0; i < 20; i++) begin
      kind = int'($urandom_range(0, 9));
      data = 8'($urandom);
      applyStimulus(makeFrame(data, kind == 0, kind != 1, kind != 2), 12);
      gap = int'($urandom_range(2, 24));
      if ($urandom_range(0, 1) == 1) begin
        readPulse();
        gap--;
      end
      repeat (gap) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    checkOutput("pending_shifts", shift_q.size(), 0);
    checkOutput("pending_frames", frame_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
